// File: rtl/booth_seq_mult_mn_if.sv
// rtl/booth_seq_mult_mn_if.sv - operand/result handshake bundle for the Booth multiplier
interface booth_seq_mult_mn_if #(
    parameter int M_WIDTH = 32,
    parameter int N_WIDTH = 32
);
    logic                       in_valid;
    logic                       in_ready;
    logic [M_WIDTH-1:0]         a;
    logic [N_WIDTH-1:0]         b;
    logic                       signed_op;
    logic                       out_valid;
    logic                       out_ready;
    logic [M_WIDTH+N_WIDTH-1:0] product;
    logic                       busy;

    modport slave (
        input  in_valid, a, b, signed_op, out_ready,
        output in_ready, out_valid, product, busy
    );

    modport master (
        output in_valid, a, b, signed_op, out_ready,
        input  in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_seq_mult_mn.sv
// rtl/booth_seq_mult_mn.sv - iterative radix-2 Booth multiplier, one step per clock
module booth_seq_mult_mn #(
    parameter int M_WIDTH = 32,
    parameter int N_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    booth_seq_mult_mn_if.slave  bus
);
    localparam int CW = $clog2(N_WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [M_WIDTH:0]           a_q, a_d;
    logic [M_WIDTH+1:0]         acc_q, acc_d;
    logic [N_WIDTH:0]           q_q, q_d;
    logic                       qm1_q, qm1_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [M_WIDTH+N_WIDTH-1:0] product_q, product_d;

    logic [M_WIDTH+1:0]         a_ext;
    logic [M_WIDTH+1:0]         acc_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        a_ext = {a_q[M_WIDTH], a_q};
        case ({q_q[0], qm1_q})
            2'b01:   acc_sum = acc_q + a_ext;
            2'b10:   acc_sum = acc_q - a_ext;
            default: acc_sum = acc_q;
        endcase

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // One extra operand bit lets the signed Booth core handle unsigned inputs exactly.
                    a_d     = {bus.signed_op & bus.a[M_WIDTH-1], bus.a};
                    q_d     = {bus.signed_op & bus.b[N_WIDTH-1], bus.b};
                    qm1_d   = 1'b0;
                    acc_d   = '0;
                    cnt_d   = CW'(N_WIDTH + 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = {acc_sum[M_WIDTH+1], acc_sum[M_WIDTH+1:1]};
                q_d   = {acc_sum[0], q_q[N_WIDTH:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    product_d = {acc_d[M_WIDTH-2:0], q_d};
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.product   = product_q;
endmodule

// File: tb/tb_booth_seq_mult_mn.sv
// tb/tb_booth_seq_mult_mn.sv - scoreboard bench for the Booth multiplier (8x8 and 12x5)
module tb_booth_seq_mult_mn;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    booth_seq_mult_mn_if #(.M_WIDTH(8),  .N_WIDTH(8)) m8 ();
    booth_seq_mult_mn_if #(.M_WIDTH(12), .N_WIDTH(5)) m12 ();

    booth_seq_mult_mn #(.M_WIDTH(8),  .N_WIDTH(8)) u_dut8  (.clk(clk), .rst(rst), .bus(m8));
    booth_seq_mult_mn #(.M_WIDTH(12), .N_WIDTH(5)) u_dut12 (.clk(clk), .rst(rst), .bus(m12));

    logic [15:0] sb8[$];
    logic [16:0] sb12[$];

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return 16'(x * y);
    endfunction

    function automatic logic [16:0] ref12(input logic [11:0] a, input logic [4:0] b, input logic s);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return 17'(x * y);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8x8 operation: accept, measure latency, hold under backpressure (optionally with junk in_valid), drain.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input int hold,
                       input bit junk, input bit use_exp, input logic [15:0] exp_i);
        int n;
        logic [15:0] got;
        n = 0;
        while (!m8.in_ready && n < 50) begin tick(); n++; end
        chk("op8_in_ready_before", {63'd0, m8.in_ready}, 64'd1);
        m8.a = a; m8.b = b; m8.signed_op = s; m8.in_valid = 1'b1;
        sb8.push_back(use_exp ? exp_i : ref8(a, b, s));
        tick();
        m8.in_valid = 1'b0;
        n = 0;
        while (!m8.out_valid && n < 40) begin tick(); n++; end
        chk("op8_latency", 64'(n), 64'd9);
        chk("op8_in_ready_done", {63'd0, m8.in_ready}, 64'd0);
        got = m8.product;
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                m8.in_valid = 1'b1; m8.a = ~a; m8.b = b + 8'd1; m8.signed_op = ~s;
            end
            tick();
            chk("op8_hold_valid", {63'd0, m8.out_valid}, 64'd1);
            chk("op8_hold_product", 64'(m8.product), 64'(got));
            chk("op8_hold_in_ready", {63'd0, m8.in_ready}, 64'd0);
        end
        m8.in_valid = 1'b0;
        m8.out_ready = 1'b1;
        tick();
        m8.out_ready = 1'b0;
        chk("op8_drain_valid", {63'd0, m8.out_valid}, 64'd0);
        chk("op8_drain_in_ready", {63'd0, m8.in_ready}, 64'd1);
        chk("op8_product", 64'(got), 64'(sb8.pop_front()));
    endtask

    task automatic op12(input logic [11:0] a, input logic [4:0] b, input logic s, input int hold,
                        input bit use_exp, input logic [16:0] exp_i);
        int n;
        logic [16:0] got;
        m12.a = a; m12.b = b; m12.signed_op = s; m12.in_valid = 1'b1;
        sb12.push_back(use_exp ? exp_i : ref12(a, b, s));
        tick();
        m12.in_valid = 1'b0;
        n = 0;
        while (!m12.out_valid && n < 40) begin tick(); n++; end
        chk("op12_latency", 64'(n), 64'd6);
        got = m12.product;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("op12_hold_product", 64'(m12.product), 64'(got));
        end
        m12.out_ready = 1'b1;
        tick();
        m12.out_ready = 1'b0;
        chk("op12_drain_in_ready", {63'd0, m12.in_ready}, 64'd1);
        chk("op12_product", 64'(got), 64'(sb12.pop_front()));
    endtask

    initial begin
        m8.in_valid = 1'b0;  m8.a = '0;  m8.b = '0;  m8.signed_op = 1'b0;  m8.out_ready = 1'b0;
        m12.in_valid = 1'b0; m12.a = '0; m12.b = '0; m12.signed_op = 1'b0; m12.out_ready = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", {63'd0, m8.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, m8.out_valid}, 64'd0);
        chk("rst_busy", {63'd0, m8.busy}, 64'd0);
        chk("rst_product", 64'(m8.product), 64'd0);

        op8(8'hFD, 8'h05, 1'b1, 0, 1'b0, 1'b1, 16'hFFF1);
        op8(8'hFF, 8'hFF, 1'b0, 0, 1'b0, 1'b1, 16'hFE01);
        op8(8'hFF, 8'hFF, 1'b1, 1, 1'b0, 1'b1, 16'h0001);
        op8(8'h80, 8'h80, 1'b1, 0, 1'b0, 1'b1, 16'h4000);
        op8(8'h7F, 8'h80, 1'b1, 0, 1'b0, 1'b1, 16'hC080);
        op8(8'h00, 8'hA7, 1'b1, 0, 1'b0, 1'b1, 16'h0000);
        op8(8'h93, 8'h5C, 1'b0, 20, 1'b1, 1'b0, 16'h0000);
        op8(8'h12, 8'h34, 1'b0, 0, 1'b0, 1'b0, 16'h0000);

        // Reset lands on the fourth CALC step; the operation must vanish.
        m8.a = 8'h55; m8.b = 8'h33; m8.signed_op = 1'b0; m8.in_valid = 1'b1;
        tick();
        m8.in_valid = 1'b0;
        tick(); tick(); tick();
        chk("pre_rst_busy", {63'd0, m8.busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", {63'd0, m8.in_ready}, 64'd1);
        chk("midrst_out_valid", {63'd0, m8.out_valid}, 64'd0);
        chk("midrst_product", 64'(m8.product), 64'd0);
        chk("midrst_busy", {63'd0, m8.busy}, 64'd0);
        op8(8'd6, 8'd7, 1'b0, 0, 1'b0, 1'b1, 16'h002A);

        op12(12'h800, 5'h10, 1'b1, 0, 1'b1, 17'h08000);
        op12(12'hFFF, 5'h1F, 1'b0, 0, 1'b1, 17'h1EFE1);

        for (int i = 0; i < 2500; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 2500; i++)
            op12(12'($urandom), 5'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, 17'h00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
